// File: rtl/input_debounce_pkg.sv
// Shared types and parameter-legality helpers for the input_debounce block.
package debounce_pkg;

    // Filter states: the two CHK_* states hold the old output level while a
    // candidate new level is being confirmed.
    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } db_state_t;

    localparam int MIN_SYNC_STAGES   = 2;
    localparam int MIN_STABLE_CYCLES = 1;

    // Evaluated at elaboration so an illegal configuration stops the build.
    function automatic bit params_legal(input int syncStages, input int stableCycles);
        return (syncStages >= MIN_SYNC_STAGES) && (stableCycles >= MIN_STABLE_CYCLES);
    endfunction

    // The debounced level is 1 in HIGH and while confirming a fall from HIGH.
    function automatic logic is_high_state(input db_state_t st);
        return (st == HIGH) || (st == CHK_LO);
    endfunction

endpackage

// File: rtl/input_debounce_sync.sv
// N-flop synchroniser bringing an asynchronous input into the clk domain.
// All stages reset to 0; the output is the last stage.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the chain; only stage 0 ever sees i_async.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Debouncer for one bouncy external input: synchronise, then require
// STABLE_CYCLES identical samples before the registered output changes.
// Optional feature macro: DEBOUNCE_EDGE_EN builds registered rise/fall pulses;
// without it rise_pulse and fall_pulse are tied low (port list unchanged).
module input_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam bit              PARAMS_OK = params_legal(SYNC_STAGES, STABLE_CYCLES);

    generate
        if (!PARAMS_OK) begin : g_badParams
            $error("input_debounce: SYNC_STAGES must be >= 2 and STABLE_CYCLES >= 1");
        end
    endgenerate

    logic             w_sync;
    db_state_t        r_state;
    db_state_t        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_dbOut;
    logic             w_dbNext;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (raw_in),
        .o_sync  (w_sync)
    );

    // Next state and stability count. Any sample agreeing with the current
    // output level during a CHK_* state throws the partial run away. With
    // STABLE_CYCLES==1 the first opposite sample switches directly, so the
    // count is left at 0 to keep it within 0..STABLE_CYCLES-1.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            LOW: begin
                if (w_sync) begin
                    w_stateNext = (STABLE_CYCLES == 1) ? HIGH : CHK_HI;
                    w_cntNext   = (STABLE_CYCLES == 1) ? '0 : CNT_W'(1);
                end else begin
                    w_cntNext = '0;
                end
            end
            CHK_HI: begin
                if (!w_sync) begin
                    w_stateNext = LOW;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = HIGH;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!w_sync) begin
                    w_stateNext = (STABLE_CYCLES == 1) ? LOW : CHK_LO;
                    w_cntNext   = (STABLE_CYCLES == 1) ? '0 : CNT_W'(1);
                end else begin
                    w_cntNext = '0;
                end
            end
            CHK_LO: begin
                if (w_sync) begin
                    w_stateNext = HIGH;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = LOW;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = LOW;
                w_cntNext   = '0;
            end
        endcase
    end

    assign w_dbNext = is_high_state(w_stateNext);

    // State, count and the registered output level, all cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_dbOut <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_dbOut <= w_dbNext;
        end
    end

    assign db_out = r_dbOut;

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses register on the same edge that updates db_out, so each is high
    // exactly in the first cycle the new level is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_dbNext & ~r_dbOut;
            r_fall <= ~w_dbNext & r_dbOut;
        end
    end

    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Randomised self-checking bench for input_debounce. Two instances share the
// same raw input: the default build (STABLE_CYCLES=4) and a STABLE_CYCLES=1
// build. A run-length reference model predicts every output each cycle.
module tb_input_debounce;

    localparam int SYNC    = 2;
    localparam int STABLE0 = 4;
    localparam int STABLE1 = 1;

`ifdef DEBOUNCE_EDGE_EN
    localparam int EDGE_EN = 1;
`else
    localparam int EDGE_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic rawIn;
    logic db0, rise0, fall0;
    logic db1, rise1, fall1;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: delay line for the synchroniser, then per-instance
    // count of consecutive samples disagreeing with the current level.
    int pipe[$];
    int mDb[2];
    int mRun[2];
    int mRise[2];
    int mFall[2];
    int stableOf[2] = '{STABLE0, STABLE1};

    always #5 clk = ~clk;

    input_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE0)
    ) dut0 (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (rawIn),
        .db_out     (db0),
        .rise_pulse (rise0),
        .fall_pulse (fall0)
    );

    input_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (rawIn),
        .db_out     (db1),
        .rise_pulse (rise1),
        .fall_pulse (fall1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        pipe.delete();
        for (int i = 0; i < SYNC; i++) pipe.push_back(0);
        for (int m = 0; m < 2; m++) begin
            mDb[m]   = 0;
            mRun[m]  = 0;
            mRise[m] = 0;
            mFall[m] = 0;
        end
    endtask

    task automatic modelEdge(input int raw, input logic rst);
        int s;
        if (rst) begin
            modelReset();
            return;
        end
        s = pipe.pop_front();
        pipe.push_back(raw);
        for (int m = 0; m < 2; m++) begin
            mRise[m] = 0;
            mFall[m] = 0;
            if (s != mDb[m]) mRun[m]++;
            else             mRun[m] = 0;
            if (mRun[m] == stableOf[m]) begin
                mDb[m]  = 1 - mDb[m];
                mRun[m] = 0;
                if (EDGE_EN == 1) begin
                    if (mDb[m] == 1) mRise[m] = 1;
                    else             mFall[m] = 1;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare all outputs 1 ns later.
    task automatic applyStimulus(input int raw, input logic rst, input string tag);
        @(negedge clk);
        rawIn = raw[0];
        reset = rst;
        @(posedge clk);
        modelEdge(raw, rst);
        #1;
        checkOutput({tag, "_db0"},   db0,   mDb[0]);
        checkOutput({tag, "_rise0"}, rise0, mRise[0]);
        checkOutput({tag, "_fall0"}, fall0, mFall[0]);
        checkOutput({tag, "_db1"},   db1,   mDb[1]);
        checkOutput({tag, "_rise1"}, rise1, mRise[1]);
        checkOutput({tag, "_fall1"}, fall1, mFall[1]);
    endtask

    initial begin
        int lat0, lat1, pulses, sawChange, val, len;

        reset = 1'b1;
        rawIn = 1'b0;
        modelReset();

        // Reset with input low, then 20 quiet cycles.
        for (int i = 0; i < 3; i++)  applyStimulus(0, 1'b1, "t1rst");
        for (int i = 0; i < 20; i++) applyStimulus(0, 1'b0, "t1");

        // Clean rise: measure latency of both builds and count rise pulses.
        lat0 = -1; lat1 = -1; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1'b0, "t2");
            if (db0 === 1'b1 && lat0 < 0) lat0 = i;
            if (db1 === 1'b1 && lat1 < 0) lat1 = i;
            if (rise0 === 1'b1) pulses++;
        end
        checkOutput("t2_latency", lat0, 5);
        checkOutput("t2_latency_s1", lat1, 2);
        checkOutput("t2_riseCount", pulses, EDGE_EN);

        // Glitchy fall: low 3, high 2, then low held.
        sawChange = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, "t4g");
            if (db0 !== 1'b1) sawChange = 1;
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1'b0, "t4g");
            if (db0 !== 1'b1) sawChange = 1;
        end
        checkOutput("t4_heldThroughGlitch", sawChange, 0);
        lat0 = -1; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1'b0, "t4");
            if (db0 === 1'b0 && lat0 < 0) lat0 = i;
            if (fall0 === 1'b1) pulses++;
        end
        checkOutput("t4_fallLatency", lat0, 5);
        checkOutput("t4_fallCount", pulses, EDGE_EN);

        // Short high runs of 1, 2 and 3 samples must all be rejected.
        sawChange = 0; pulses = 0;
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < w; i++) begin
                applyStimulus(1, 1'b0, "t3");
                if (db0 !== 1'b0) sawChange = 1;
                if (rise0 !== 1'b0) pulses++;
            end
            for (int i = 0; i < 5; i++) begin
                applyStimulus(0, 1'b0, "t3");
                if (db0 !== 1'b0) sawChange = 1;
                if (rise0 !== 1'b0) pulses++;
            end
        end
        checkOutput("t3_dbStayedLow", sawChange, 0);
        checkOutput("t3_noRise", pulses, 0);

        // Reset in the middle of confirming a rise, input held high.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, "t5pre");
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("t5_dbAtReset", db0, 0);
        checkOutput("t5_riseAtReset", rise0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1'b1, "t5rst");
        lat0 = -1; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, 1'b0, "t5");
            if (db0 === 1'b1 && lat0 < 0) lat0 = i;
            if (rise0 === 1'b1) pulses++;
        end
        checkOutput("t5_latencyAfterRelease", lat0, 5);
        checkOutput("t5_riseCount", pulses, EDGE_EN);

        // Random runs of random length with occasional resets.
        for (int r = 0; r < 600; r++) begin
            val = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            if ($urandom_range(0, 99) < 2) begin
                for (int i = 0; i < 2; i++) applyStimulus(val, 1'b1, "rndRst");
            end
            for (int i = 0; i < len; i++) applyStimulus(val, 1'b0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
